// File: rtl/rgmii_rx_decoder.sv
// RGMII receive decoder: DDR/nibble byte assembly, preamble/SFD strip, framed byte stream, stats.
// Optional in-band link status decode enabled by defining RGMII_RX_INBAND_STATUS_EN.
module rgmii_rx_decoder #(
  parameter int unsigned MIN_PREAMBLE = 1,
  parameter int unsigned STAT_W       = 16,
  parameter int unsigned IN_REG       = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        ddr_q,
  input  logic              speed_1g,
  output logic [7:0]        out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_err,
  output logic [STAT_W-1:0] frame_cnt,
  output logic [STAT_W-1:0] err_cnt,
  output logic              link_up,
  output logic [1:0]        link_speed,
  output logic              full_duplex
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

  state_t     r_state;
  logic [9:0] w_q;
  logic       w_dv, w_er, w_mode, w_push;

  // Optional input retiming register; resets to "dv high" so a live frame stays ignored.
  generate
    if (IN_REG != 0) begin : g_inreg
      logic [9:0] r_in;
      always_ff @(posedge clk) begin
        if (!rst_n) r_in <= 10'h210;
        else        r_in <= ddr_q;
      end
      assign w_q = r_in;
    end else begin : g_noreg
      assign w_q = ddr_q;
    end
  endgenerate

  logic       r_mode;
  logic       r_s1_dv, r_s1_bv, r_s1_er, r_s1_odd;
  logic [7:0] r_s1_byte;
  logic       r_nib_ph;
  logic [3:0] r_nib_lo;

  assign w_dv   = w_q[4];
  assign w_er   = w_q[4] ^ w_q[9];
  assign w_mode = (r_state == S_IDLE) ? speed_1g : r_mode;

  // S1: decode and nibble pairing (low nibble first, phase restarts whenever dv is low)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode    <= 1'b1;
      r_s1_dv   <= 1'b1;
      r_s1_bv   <= 1'b0;
      r_s1_er   <= 1'b0;
      r_s1_odd  <= 1'b0;
      r_s1_byte <= 8'h00;
      r_nib_ph  <= 1'b0;
      r_nib_lo  <= 4'h0;
    end else begin
      r_mode   <= w_mode;
      r_s1_dv  <= w_dv;
      r_s1_er  <= w_er;
      r_s1_odd <= !w_mode && !w_dv && r_nib_ph;
      if (w_mode) begin
        r_s1_byte <= {w_q[8:5], w_q[3:0]};
        r_s1_bv   <= w_dv;
        r_nib_ph  <= 1'b0;
      end else begin
        r_s1_byte <= {w_q[3:0], r_nib_lo};
        r_s1_bv   <= w_dv && r_nib_ph;
        r_nib_ph  <= w_dv && !r_nib_ph;
        if (w_dv && !r_nib_ph) r_nib_lo <= w_q[3:0];
      end
    end
  end

  // Hold register is released once the next byte is known to exist: in nibble mode
  // that is the low-nibble cycle with the high nibble already valid at the input.
  assign w_push = r_mode ? r_s1_bv : (r_s1_dv && !r_s1_bv && w_dv);

  logic       r_prev_dv, r_ferr, r_first, r_h_valid;
  logic [2:0] r_pre_cnt;
  logic [7:0] r_h;
  logic       r_inc_frame, r_inc_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prev_dv   <= 1'b1;
      r_ferr      <= 1'b0;
      r_first     <= 1'b0;
      r_h_valid   <= 1'b0;
      r_pre_cnt   <= 3'd0;
      r_h         <= 8'h00;
      r_inc_frame <= 1'b0;
      r_inc_err   <= 1'b0;
      out_data    <= 8'h00;
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      out_err     <= 1'b0;
      r_inc_frame <= 1'b0;
      r_inc_err   <= 1'b0;
      if (r_s1_bv || !r_s1_dv) r_prev_dv <= r_s1_dv;
      case (r_state)
        S_IDLE: begin
          r_h_valid <= 1'b0;
          r_first   <= 1'b1;
          if (!r_s1_dv)     r_ferr <= 1'b0;
          else if (r_s1_er) r_ferr <= 1'b1;
          if (r_s1_bv && !r_prev_dv) begin
            if (r_s1_byte == 8'h55) begin
              r_state   <= S_PRE;
              r_pre_cnt <= 3'd1;
            end else begin
              r_state   <= S_DROP;
              r_inc_err <= 1'b1;
            end
          end
        end
        S_PRE: begin
          if (r_s1_dv && r_s1_er) r_ferr <= 1'b1;
          if (!r_s1_dv) begin
            r_state   <= S_IDLE;
            r_inc_err <= 1'b1;
          end else if (r_s1_bv) begin
            if (r_s1_byte == 8'h55) begin
              if (r_pre_cnt != 3'd7) r_pre_cnt <= r_pre_cnt + 3'd1;
            end else if (r_s1_byte == 8'hD5 && r_pre_cnt >= 3'(MIN_PREAMBLE)) begin
              r_state <= S_DATA;
            end else begin
              r_state   <= S_DROP;
              r_inc_err <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (r_s1_dv && r_s1_er) r_ferr <= 1'b1;
          if (!r_s1_dv) begin
            r_state <= S_IDLE;
            if (r_h_valid) begin
              out_data    <= r_h;
              out_valid   <= 1'b1;
              out_sop     <= r_first;
              out_eop     <= 1'b1;
              out_err     <= r_ferr || r_s1_odd;
              r_inc_frame <= !(r_ferr || r_s1_odd);
              r_inc_err   <= r_ferr || r_s1_odd;
            end else begin
              r_inc_err <= 1'b1;
            end
          end else begin
            if (w_push && r_h_valid) begin
              out_data  <= r_h;
              out_valid <= 1'b1;
              out_sop   <= r_first;
              r_first   <= 1'b0;
              r_h_valid <= 1'b0;
            end
            if (r_s1_bv) begin
              r_h       <= r_s1_byte;
              r_h_valid <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (!r_s1_dv) r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating statistics, one cycle behind the eop/drop decision
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (r_inc_frame && frame_cnt != {STAT_W{1'b1}}) frame_cnt <= frame_cnt + STAT_W'(1);
      if (r_inc_err && err_cnt != {STAT_W{1'b1}})     err_cnt   <= err_cnt + STAT_W'(1);
    end
  end

`ifdef RGMII_RX_INBAND_STATUS_EN
  logic [3:0] r_s1_rxd;

  // Inter-frame RXD carries link status while the line is idle and error-free
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_rxd    <= 4'h0;
      link_up     <= 1'b0;
      link_speed  <= 2'b00;
      full_duplex <= 1'b0;
    end else begin
      r_s1_rxd <= w_q[3:0];
      if (r_state == S_IDLE && !r_s1_dv && !r_s1_er) begin
        link_up     <= r_s1_rxd[0];
        link_speed  <= r_s1_rxd[2:1];
        full_duplex <= r_s1_rxd[3];
      end
    end
  end
`else
  assign link_up     = 1'b0;
  assign link_speed  = 2'b00;
  assign full_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Directed bench for rgmii_rx_decoder: table of frame scenarios plus reset, saturation and status sequences.
module tb_rgmii_rx_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] ddr_q;
  logic       speed_1g;
  logic [7:0] out_data;
  logic       out_valid, out_sop, out_eop, out_err;
  logic [3:0] frame_cnt, err_cnt;
  logic       link_up;
  logic [1:0] link_speed;
  logic       full_duplex;

  rgmii_rx_decoder #(.MIN_PREAMBLE(1), .STAT_W(4), .IN_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .ddr_q(ddr_q), .speed_1g(speed_1g),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_err(out_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt),
    .link_up(link_up), .link_speed(link_speed), .full_duplex(full_duplex)
  );

  always #5 clk = ~clk;

  int unsigned cycle_no = 0;
  always @(posedge clk) cycle_no <= cycle_no + 1;

  logic [7:0]  q_data[$];
  logic [2:0]  q_fl[$];
  int unsigned q_cyc[$];

  always @(negedge clk) begin
    if (out_valid) begin
      q_data.push_back(out_data);
      q_fl.push_back({out_sop, out_eop, out_err});
      q_cyc.push_back(cycle_no);
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic       spd;
    int         n_pre;
    logic [7:0] sfd;
    int         n_data;
    int         er_idx;
    logic       odd;
    int         exp_beats;
    logic       exp_err;
    logic       exp_good;
    logic       exp_bad;
  } vec_t;

  logic [3:0] idle_rxd = 4'h0;
  logic [3:0] exp_frames = 4'd0;
  logic [3:0] exp_errs = 4'd0;

  function automatic logic [3:0] sat4(input logic [3:0] x);
    return (x == 4'hF) ? x : x + 4'd1;
  endfunction

  task automatic drive(input logic [9:0] q);
    ddr_q = q;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    drive({1'b0, 4'h0, 1'b0, idle_rxd});
  endtask

  task automatic send_byte(input logic spd, input logic [7:0] b, input logic er);
    if (spd) drive({~er, b[7:4], 1'b1, b[3:0]});
    else begin
      drive({~er, 4'h0, 1'b1, b[3:0]});
      drive({1'b1, 4'h0, 1'b1, b[7:4]});
    end
  endtask

  task automatic send_frame(input vec_t v, input logic [7:0] base, output int unsigned first_cyc);
    first_cyc = 0;
    speed_1g = v.spd;
    for (int i = 0; i < v.n_pre; i++) send_byte(v.spd, 8'h55, 1'b0);
    send_byte(v.spd, v.sfd, 1'b0);
    for (int i = 0; i < v.n_data; i++) begin
      if (i == 0) first_cyc = v.spd ? cycle_no : cycle_no + 1;
      send_byte(v.spd, base + 8'(i), i == v.er_idx);
    end
    if (v.odd) drive({1'b1, 4'h0, 1'b1, 4'hA});
    repeat (12) drive_idle();
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int unsigned fc;
    int          bad;
    logic [7:0]  base;
    logic [2:0]  ef;
    base = 8'(k * 7);
    q_data.delete(); q_fl.delete(); q_cyc.delete();
    send_frame(v, base, fc);
    if (v.exp_good) exp_frames = sat4(exp_frames);
    if (v.exp_bad)  exp_errs   = sat4(exp_errs);
    check($sformatf("v%0d beats", k), 32'(q_data.size()), 32'(v.exp_beats));
    if (v.exp_beats > 0 && q_data.size() == v.exp_beats) begin
      bad = 0;
      for (int i = 0; i < v.exp_beats; i++) if (q_data[i] !== base + 8'(i)) bad++;
      check($sformatf("v%0d data", k), 32'(bad), 32'd0);
      bad = 0;
      for (int i = 0; i < v.exp_beats; i++) begin
        ef = {i == 0, i == v.exp_beats - 1, (i == v.exp_beats - 1) && v.exp_err};
        if (q_fl[i] !== ef) bad++;
      end
      check($sformatf("v%0d sop/eop/err", k), 32'(bad), 32'd0);
      check($sformatf("v%0d latency", k), q_cyc[0] - fc, 32'd3);
      bad = 0;
      for (int i = 1; i < v.exp_beats; i++) begin
        if (v.spd && (q_cyc[i] - q_cyc[i-1]) != 1) bad++;
        if (!v.spd && (q_cyc[i] - q_cyc[i-1]) < 2) bad++;
      end
      check($sformatf("v%0d spacing", k), 32'(bad), 32'd0);
    end
    check($sformatf("v%0d frame_cnt", k), 32'(frame_cnt), 32'(exp_frames));
    check($sformatf("v%0d err_cnt", k), 32'(err_cnt), 32'(exp_errs));
  endtask

  vec_t vecs[10];

  initial begin
    int unsigned fc;
    vec_t runt;
    //          spd  pre sfd    data er  odd beats err  good  bad
    vecs[0] = '{1'b1, 7, 8'hD5, 64, -1, 1'b0, 64, 1'b0, 1'b1, 1'b0}; // 1G clean
    vecs[1] = '{1'b0, 7, 8'hD5, 64, -1, 1'b0, 64, 1'b0, 1'b1, 1'b0}; // 100M clean
    vecs[2] = '{1'b1, 7, 8'hD5, 64, 10, 1'b0, 64, 1'b1, 1'b0, 1'b1}; // 1G er on byte 10
    vecs[3] = '{1'b1, 7, 8'hD5,  0, -1, 1'b0,  0, 1'b0, 1'b0, 1'b1}; // SFD then dv low
    vecs[4] = '{1'b0, 7, 8'hD5, 64, -1, 1'b1, 64, 1'b1, 1'b0, 1'b1}; // 129 nibbles
    vecs[5] = '{1'b1, 1, 8'hD5,  1, -1, 1'b0,  1, 1'b0, 1'b1, 1'b0}; // single byte, min preamble
    vecs[6] = '{1'b1, 3, 8'h12,  4, -1, 1'b0,  0, 1'b0, 1'b0, 1'b1}; // bad SFD
    vecs[7] = '{1'b1, 0, 8'hD5,  4, -1, 1'b0,  0, 1'b0, 1'b0, 1'b1}; // no preamble
    vecs[8] = '{1'b0, 2, 8'hD5,  1, -1, 1'b0,  1, 1'b0, 1'b1, 1'b0}; // 100M single byte
    vecs[9] = '{1'b0, 7, 8'hD5, 20,  5, 1'b0, 20, 1'b1, 1'b0, 1'b1}; // 100M er on byte 5

    rst_n = 1'b0; ddr_q = 10'h000; speed_1g = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_data", 32'(out_data), 32'd0);
    check("rst out flags", 32'({out_valid, out_sop, out_eop, out_err}), 32'd0);
    check("rst counters", 32'({frame_cnt, err_cnt}), 32'd0);
    check("rst link", 32'({link_up, link_speed, full_duplex}), 32'd0);
    rst_n = 1'b1;
    repeat (4) drive_idle();

    for (int k = 0; k < 10; k++) run_vec(vecs[k], k);

    // Drive err_cnt into saturation with runts
    runt = '{1'b1, 1, 8'hD5, 0, -1, 1'b0, 0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 12; k++) begin
      send_frame(runt, 8'h00, fc);
      exp_errs = sat4(exp_errs);
      check($sformatf("sat err_cnt %0d", k), 32'(err_cnt), 32'(exp_errs));
    end
    check("sat err_cnt held", 32'(err_cnt), 32'hF);

    // Reset mid-frame: outputs clear, the live frame is ignored afterwards
    speed_1g = 1'b1;
    repeat (7) send_byte(1'b1, 8'h55, 1'b0);
    send_byte(1'b1, 8'hD5, 1'b0);
    for (int i = 0; i < 10; i++) send_byte(1'b1, 8'(i), 1'b0);
    check("pre-reset streaming", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    send_byte(1'b1, 8'd10, 1'b0);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst out_data", 32'(out_data), 32'd0);
    check("midrst counters", 32'({frame_cnt, err_cnt}), 32'd0);
    rst_n = 1'b1;
    q_data.delete(); q_fl.delete(); q_cyc.delete();
    for (int i = 11; i < 31; i++) send_byte(1'b1, 8'(i), 1'b0);
    repeat (12) drive_idle();
    check("post-reset ignored beats", 32'(q_data.size()), 32'd0);
    check("post-reset counters", 32'({frame_cnt, err_cnt}), 32'd0);
    exp_frames = 4'd0;
    exp_errs   = 4'd0;
    run_vec(vecs[0], 0);

    // In-band status from idle RXD
    idle_rxd = 4'hD;
    repeat (6) drive_idle();
`ifdef RGMII_RX_INBAND_STATUS_EN
    check("inband status", 32'({link_up, link_speed, full_duplex}), 32'b1101);
`else
    check("inband status", 32'({link_up, link_speed, full_duplex}), 32'b0000);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
